shuffle_ctrl: RTL and testbench

- Controller for the shuffle-register resource used by the MOVPERMUTE instruction group. Owns a DEPTH-entry shuffle data bank, a permutation index table, a read index pointer and an LFSR.
- Sequences the multi-cycle PERMUTE (Fisher-Yates shuffle of the index table) and raises the pipeline hold flag while it runs.
- Sits beside ex: ex forwards decoded MOVPERMUTE commands and takes rd_data_o for register write-back.

---
 rtl/shuffle_pkg.sv | 28 ++
 rtl/shuffle_lfsr.sv | 29 ++
 rtl/shuffle_ctrl.sv | 156 +++++++++++++++
 tb/tb_shuffle_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shuffle_pkg.sv
// Shared definitions for the shuffle-register controller: command
// encodings, controller states and LFSR constants.
package shuffle_pkg;

  // MOVPERMUTE funct3 encodings (3'b111 is unassigned and ignored)
  localparam logic [2:0] MOVTOSH    = 3'b000;
  localparam logic [2:0] IMMTOSH    = 3'b001;
  localparam logic [2:0] PERMUTE    = 3'b010;
  localparam logic [2:0] MOVTORD    = 3'b011;
  localparam logic [2:0] INITIND    = 3'b100;
  localparam logic [2:0] INCIND     = 3'b101;
  localparam logic [2:0] MOVTORDIND = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  // One step of the right-shifting Galois LFSR
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/shuffle_lfsr.sv
// 32-bit Galois LFSR with synchronous seed load and step enable.
// Load takes priority over step. Reused by the random-dispatch logic.
module shuffle_lfsr
  import shuffle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] value
);

  logic [31:0] r_lfsr;

  // Seed load or advance one step; reset returns to the fixed seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (load) begin
      r_lfsr <= seed;
    end else if (step) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign value = r_lfsr;

endmodule

// File: rtl/shuffle_ctrl.sv
// Shuffle-register controller for the MOVPERMUTE group: data bank,
// permutation table, read index and a multi-cycle Fisher-Yates PERMUTE
// that holds the pipeline while it runs.
module shuffle_ctrl
  import shuffle_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  input  logic [2:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [31:0]       cmd_seed_i,
  output logic              hold_flag_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [IDX_W-1:0]  ind_o,
  output logic              ind_wrap_o,
  output logic              err_o
);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [IDX_W-1:0]  r_perm [DEPTH];
  logic [IDX_W-1:0]  r_wr_ptr;
  logic [IDX_W-1:0]  r_ind;
  logic [IDX_W-1:0]  r_i;
  logic              r_wrap;
  logic              r_err;

  logic              w_accept;
  logic              w_perm_start;
  logic              w_take;
  logic [IDX_W-1:0]  w_mask;
  logic [IDX_W-1:0]  w_j;
  logic [31:0]       w_lfsr;
  logic              w_unused_lfsr;

  // Commands are only taken while idle; anything else is dropped
  assign w_accept     = cmd_valid_i && (r_state == IDLE);
  assign w_perm_start = w_accept && (cmd_op_i == PERMUTE);

  // mask(i): every bit at or below the MSB of i is set
  for (genvar gi = 0; gi < IDX_W; gi++) begin : g_mask
    assign w_mask[gi] = |r_i[IDX_W-1:gi];
  end

  // Candidate swap partner; values above i are rejected and retried
  assign w_j    = w_lfsr[IDX_W-1:0] & w_mask;
  assign w_take = (r_state == PICK) && (w_j <= r_i);

  assign w_unused_lfsr = ^w_lfsr[31:IDX_W];

  shuffle_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (w_perm_start && (cmd_seed_i != 32'h0)),
    .seed  (cmd_seed_i),
    .step  (r_state == PICK),
    .value (w_lfsr)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: PICK runs until the swap at i=1, then one DONE cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_perm_start) w_state_next = PICK;
      PICK:    if (w_take && (r_i == IDX_W'(1))) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Data bank: circular write through wr_ptr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
    end else if (w_accept && ((cmd_op_i == MOVTOSH) || (cmd_op_i == IMMTOSH))) begin
      r_data[r_wr_ptr] <= cmd_data_i;
    end
  end

  // Permutation table: identity on reset/start, swap on each taken pick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_perm[k] <= IDX_W'(k);
    end else if (w_perm_start) begin
      for (int k = 0; k < DEPTH; k++) r_perm[k] <= IDX_W'(k);
    end else if (w_take) begin
      r_perm[r_i] <= r_perm[w_j];
      r_perm[w_j] <= r_perm[r_i];
    end
  end

  // Write pointer, read index, wrap pulse and shuffle position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_ind    <= '0;
      r_i      <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_accept) begin
        case (cmd_op_i)
          MOVTOSH, IMMTOSH: r_wr_ptr <= r_wr_ptr + 1'b1;
          INITIND: begin
            r_ind    <= '0;
            r_wr_ptr <= '0;
          end
          INCIND: begin
            r_ind  <= r_ind + 1'b1;
            r_wrap <= (r_ind == IDX_W'(DEPTH - 1));
          end
          PERMUTE: r_i <= IDX_W'(DEPTH - 1);
          default: ;
        endcase
      end else if (w_take) begin
        r_i <= r_i - 1'b1;
      end
    end
  end

  // Sticky drop flag: any command offered while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_err <= 1'b0;
    else if (cmd_valid_i && (r_state != IDLE)) r_err <= 1'b1;
  end

  // Same-cycle read port for MOVTORD / MOVTORDIND
  always_comb begin
    rd_data_o = '0;
    if (w_accept && (cmd_op_i == MOVTORD)) begin
      rd_data_o = r_data[cmd_data_i[IDX_W-1:0]];
    end else if (w_accept && (cmd_op_i == MOVTORDIND)) begin
      rd_data_o = r_data[r_perm[r_ind]];
    end
  end

  assign hold_flag_o = (r_state != IDLE) || w_perm_start;
  assign busy_o      = (r_state != IDLE);
  assign ind_o       = r_ind;
  assign ind_wrap_o  = r_wrap;
  assign err_o       = r_err;

endmodule

// File: tb/tb_shuffle_ctrl.sv
// Scoreboard bench for shuffle_ctrl: the driver pushes expected read data,
// a monitor pops and compares whenever a read command is on the bus.
module tb_shuffle_ctrl;
  import shuffle_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic [2:0]  cmd_op_i = 3'b0;
  logic [31:0] cmd_data_i = '0;
  logic [31:0] cmd_seed_i = '0;
  logic        hold_flag_o, busy_o, ind_wrap_o, err_o;
  logic [31:0] rd_data_o;
  logic [3:0]  ind_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];
  int          tag_q [$];
  logic [31:0] last_rd = '0;

  // Reference model state
  logic [31:0] m_data [16];
  int          m_perm [16];
  logic [31:0] m_lfsr = 32'h1;
  int          m_wr   = 0;
  int          m_ind  = 0;

  shuffle_ctrl #(.DEPTH(16), .IDX_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid_i), .cmd_op_i(cmd_op_i),
    .cmd_data_i(cmd_data_i), .cmd_seed_i(cmd_seed_i), .hold_flag_o(hold_flag_o),
    .busy_o(busy_o), .rd_data_o(rd_data_o), .ind_o(ind_o),
    .ind_wrap_o(ind_wrap_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Monitor: compare every read command against the next queued expectation
  initial begin
    logic [31:0] e;
    int          t;
    forever begin
      @(negedge clk);
      if (!rst && cmd_valid_i && (cmd_op_i == MOVTORD || cmd_op_i == MOVTORDIND)) begin
        last_rd = rd_data_o;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected actual=%h required=<none>", rd_data_o);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (rd_data_o !== e) begin
            n_fail++;
            $display("FAIL rd_data tag=%0d actual=%h required=%h", t, rd_data_o, e);
          end else begin
            $display("rd tag=%0d data=%h ok", t, rd_data_o);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end else begin
      $display("chk %s = %h ok", nm, act);
    end
  endtask

  // One command for one cycle; entered and left at posedge+1
  task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [31:0] s);
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_data_i = d; cmd_seed_i = s;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    issue(MOVTOSH, d, 32'h0);
    m_data[m_wr] = d;
    m_wr = (m_wr + 1) % 16;
  endtask

  task automatic rd_exp(input logic [31:0] idx, input logic [31:0] exp, input int tag);
    exp_q.push_back(exp); tag_q.push_back(tag);
    issue(MOVTORD, idx, 32'h0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin m_data[k] = '0; m_perm[k] = k; end
    m_lfsr = 32'h1; m_wr = 0; m_ind = 0;
  endtask

  // Fisher-Yates on the model table; returns number of rejected picks
  function automatic int model_permute(input logic [31:0] seed);
    int i, j, rej, msk, t;
    for (int k = 0; k < 16; k++) m_perm[k] = k;
    if (seed != 0) m_lfsr = seed;
    i = 15; rej = 0;
    while (i > 0) begin
      msk = 1;
      while (msk < i) msk = msk * 2 + 1;
      j = int'(m_lfsr[3:0]) & msk;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
      if (j <= i) begin
        t = m_perm[i]; m_perm[i] = m_perm[j]; m_perm[j] = t; i--;
      end else begin
        rej++;
      end
    end
    return rej;
  endfunction

  task automatic do_permute(input logic [31:0] seed, input string nm);
    int rej, cnt;
    rej = model_permute(seed);
    cmd_valid_i = 1'b1; cmd_op_i = PERMUTE; cmd_data_i = '0; cmd_seed_i = seed;
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!hold_flag_o) break;
      cnt++;
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
    end
    cmd_valid_i = 1'b0;
    check(nm, cnt, 32'(17 + rej));
    @(posedge clk); #1;
  endtask

  // Walk all 16 indices through MOVTORDIND/INCIND; data[k] = 32'hB0+k
  task automatic sweep(input int base);
    int wraps, wrap_at;
    logic [15:0] seen;
    issue(INITIND, 32'h0, 32'h0);
    m_ind = 0; m_wr = 0;
    wraps = 0; wrap_at = -1; seen = '0;
    for (int s = 0; s < 16; s++) begin
      exp_q.push_back(m_data[m_perm[m_ind]]); tag_q.push_back(base + s);
      issue(MOVTORDIND, 32'h0, 32'h0);
      seen[last_rd[3:0]] = 1'b1;
      issue(INCIND, 32'h0, 32'h0);
      if (ind_wrap_o) begin wraps++; wrap_at = s; end
      m_ind = (m_ind + 1) % 16;
      check("ind", 32'(ind_o), 32'(m_ind));
    end
    check("distinct", 32'(seen), 32'h0000_FFFF);
    check("wrap_count", wraps, 32'd1);
    check("wrap_step", wrap_at, 32'd15);
  endtask

  task automatic load_b();
    issue(INITIND, 32'h0, 32'h0);
    m_wr = 0; m_ind = 0;
    for (int k = 0; k < 16; k++) wr(32'hB0 + k);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_hold", 32'(hold_flag_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_rd", rd_data_o, 32'h0);
    check("rst_ind", 32'(ind_o), 32'h0);
    check("rst_wrap", 32'(ind_wrap_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    exp_q.push_back(32'h0); tag_q.push_back(1);
    issue(MOVTORDIND, 32'h0, 32'h0);

    // Write / read back, including wrap of the write pointer
    for (int k = 0; k < 4; k++) wr(32'hA0 + k);
    rd_exp(32'd2, 32'hA2, 2);
    for (int k = 4; k < 16; k++) wr(32'hA0 + k);
    wr(32'hC0);
    rd_exp(32'd0, 32'hC0, 3);
    rd_exp(32'd1, 32'hA1, 4);
    rd_exp(32'hFFFF_FF03, 32'hA3, 5);

    // Undefined funct3 is silently ignored
    issue(3'b111, 32'h1234, 32'h0);
    check("undef_err", 32'(err_o), 32'h0);
    check("undef_busy", 32'(busy_o), 32'h0);

    // Identity walk, then PERMUTE with seed, same seed again, seed 0
    load_b();
    sweep(100);
    do_permute(32'hDEAD_BEEF, "hold_p1");
    sweep(200);
    do_permute(32'hDEAD_BEEF, "hold_p2");
    sweep(300);
    do_permute(32'h0, "hold_p3");
    sweep(400);

    // Busy drop: MOVTOSH during PICK is discarded and flags err
    begin
      int rej;
      rej = model_permute(32'h1234_5678);
      issue(PERMUTE, 32'h0, 32'h1234_5678);
      @(posedge clk); #1;
      check("drop_busy", 32'(busy_o), 32'h1);
      issue(MOVTOSH, 32'hDEAD_0000, 32'h0);
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (!hold_flag_o) break;
      end
      @(posedge clk); #1;
      check("drop_idle", 32'(busy_o), 32'h0);
      check("drop_err", 32'(err_o), 32'h1);
      rd_exp(32'd0, 32'hB0, 6);
      wr(32'hE0);
      rd_exp(32'd0, 32'hE0, 7);
      issue(INCIND, 32'h0, 32'h0);
      check("err_sticky", 32'(err_o), 32'h1);
    end

    // Reset during PICK cycle 5
    load_b();
    begin
      int rej;
      rej = model_permute(32'hDEAD_BEEF);
      issue(PERMUTE, 32'h0, 32'hDEAD_BEEF);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_hold", 32'(hold_flag_o), 32'h0);
      check("mid_rst_busy", 32'(busy_o), 32'h0);
      check("mid_rst_err", 32'(err_o), 32'h0);
      check("mid_rst_ind", 32'(ind_o), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
    end
    load_b();
    sweep(500);
    do_permute(32'h0, "hold_p4");
    sweep(600);

    check("sb_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
